// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RISC-V sequencing controller.
// Covers opcodes, FSM states, ALU control codes, source-B selects and instruction classes.
package risc_v_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_ILOGIC = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [2:0] ALU_R      = 3'b000;
  localparam logic [2:0] ALU_ILOGIC = 3'b001;
  localparam logic [2:0] ALU_LUI    = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_SUB    = 3'b100;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // The trap state only exists when illegal opcodes are trapped.
  typedef enum logic [2:0] {
    S_FETCH      = 3'b000,
    S_DECODE     = 3'b001,
    S_EXECUTE    = 3'b010,
    S_MEM_ACCESS = 3'b011,
`ifdef ILLEGAL_TRAP_EN
    S_WRITEBACK  = 3'b100,
    S_TRAP       = 3'b110
`else
    S_WRITEBACK  = 3'b100
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_R       = 3'd1,
    CLS_ILOGIC  = 3'd2,
    CLS_LUI     = 3'd3,
    CLS_LOAD    = 3'd4,
    CLS_STORE   = 3'd5,
    CLS_BRANCH  = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory handshake bundle.
// master: the sequencing controller; slave: the datapath and memory side.
interface multicycle_control_fsm_if;
  logic [6:0] OP_i;
  logic       Zero_i;
  logic       Mem_Ready_i;
  logic       Mem_Read_o;
  logic       Mem_Write_o;
  logic       IorD_o;
  logic       IR_Write_o;
  logic       PC_Write_o;
  logic       Branch_o;
  logic       ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic       Mem_to_Reg_o;
  logic       Reg_Write_o;
  logic       Mem_Timeout_o;
  logic [2:0] State_o;

  modport master (
    input  OP_i, Zero_i, Mem_Ready_i,
    output Mem_Read_o, Mem_Write_o, IorD_o, IR_Write_o, PC_Write_o, Branch_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Mem_to_Reg_o, Reg_Write_o,
           Mem_Timeout_o, State_o
  );

  modport slave (
    output OP_i, Zero_i, Mem_Ready_i,
    input  Mem_Read_o, Mem_Write_o, IorD_o, IR_Write_o, PC_Write_o, Branch_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Mem_to_Reg_o, Reg_Write_o,
           Mem_Timeout_o, State_o
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational opcode classifier: maps IR[6:0] onto the controller's instruction class.
module instr_class_decode
  import risc_v_ctrl_pkg::*;
(
  input  logic [6:0]   op,
  output instr_class_t cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OPC_R:      cls = CLS_R;
      OPC_ILOGIC: cls = CLS_ILOGIC;
      OPC_LUI:    cls = CLS_LUI;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V sequencer: FETCH/DECODE/EXECUTE/MEM_ACCESS/WRITEBACK with memory timeout.
// Define ILLEGAL_TRAP_EN to park illegal opcodes in a TRAP state; otherwise they run as NOPs.
module multicycle_control_fsm
  import risc_v_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  state_t       state;
  instr_class_t cls;
  instr_class_t dec_cls;
  logic [7:0]   wait_cnt;
  logic         timeout_q;
  logic         waiting;
  logic         abort;

  instr_class_decode u_decode (
    .op  (bus.OP_i),
    .cls (dec_cls)
  );

  // A ready in the limit cycle still completes, so abort needs ready low.
  assign waiting = ((state == S_FETCH) || (state == S_MEM_ACCESS)) && !bus.Mem_Ready_i;
  assign abort   = waiting && (wait_cnt == 8'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      cls       <= CLS_NOP;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= (waiting && !abort) ? wait_cnt + 8'd1 : 8'd0;
      if (abort) timeout_q <= 1'b1;
      case (state)
        S_FETCH: begin
          if (bus.Mem_Ready_i) state <= S_DECODE;
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cls)
            CLS_LOAD, CLS_STORE:          state <= S_MEM_ACCESS;
            CLS_R, CLS_ILOGIC, CLS_LUI:   state <= S_WRITEBACK;
            default:                      state <= S_FETCH;
          endcase
        end
        S_MEM_ACCESS: begin
          if (bus.Mem_Ready_i)  state <= (cls == CLS_LOAD) ? S_WRITEBACK : S_FETCH;
          else if (abort)       state <= S_FETCH;
        end
        S_WRITEBACK: state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:      state <= S_TRAP;
`endif
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Strobes are forced low during reset so an interrupted access never writes.
  always_comb begin
    bus.Mem_Read_o    = 1'b0;
    bus.Mem_Write_o   = 1'b0;
    bus.IorD_o        = 1'b0;
    bus.IR_Write_o    = 1'b0;
    bus.PC_Write_o    = 1'b0;
    bus.Branch_o      = 1'b0;
    bus.ALU_Src_A_o   = 1'b0;
    bus.ALU_Src_B_o   = SRCB_RS2;
    bus.ALU_Op_o      = ALU_R;
    bus.Mem_to_Reg_o  = 1'b0;
    bus.Reg_Write_o   = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.Mem_Read_o  = 1'b1;
          bus.ALU_Src_B_o = SRCB_FOUR;
          bus.ALU_Op_o    = ALU_ADD;
          bus.IR_Write_o  = bus.Mem_Ready_i;
          bus.PC_Write_o  = bus.Mem_Ready_i;
        end
        S_DECODE: begin
          bus.ALU_Src_B_o = SRCB_IMM;
          bus.ALU_Op_o    = ALU_ADD;
        end
        S_EXECUTE: begin
          bus.ALU_Src_A_o = 1'b1;
          case (cls)
            CLS_R:      begin bus.ALU_Src_B_o = SRCB_RS2; bus.ALU_Op_o = ALU_R;      end
            CLS_ILOGIC: begin bus.ALU_Src_B_o = SRCB_IMM; bus.ALU_Op_o = ALU_ILOGIC; end
            CLS_LUI:    begin bus.ALU_Src_B_o = SRCB_IMM; bus.ALU_Op_o = ALU_LUI;    end
            CLS_LOAD,
            CLS_STORE:  begin bus.ALU_Src_B_o = SRCB_IMM; bus.ALU_Op_o = ALU_ADD;    end
            CLS_BRANCH: begin
              bus.ALU_Src_B_o = SRCB_RS2;
              bus.ALU_Op_o    = ALU_SUB;
              bus.Branch_o    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM_ACCESS: begin
          bus.IorD_o      = 1'b1;
          bus.Mem_Read_o  = (cls == CLS_LOAD);
          bus.Mem_Write_o = (cls == CLS_STORE);
        end
        S_WRITEBACK: begin
          bus.Reg_Write_o  = 1'b1;
          bus.Mem_to_Reg_o = (cls == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign bus.Mem_Timeout_o = timeout_q;
  assign bus.State_o       = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction expected traces built from the
// instruction's class and the planned memory wait counts, then replayed cycle by cycle.
module tb_multicycle_control_fsm;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       rd;
    logic       wr;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic       br;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] op;
    logic       m2r;
    logic       rw;
    logic       to;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  bit    sticky = 1'b0;
  vec_t  expQ[$];
  vec_t  mskQ[$];
  bit    rdyQ[$];
  string tagQ[$];

  function automatic vec_t observe();
    vec_t v;
    v.st   = bus.State_o;
    v.rd   = bus.Mem_Read_o;
    v.wr   = bus.Mem_Write_o;
    v.iord = bus.IorD_o;
    v.irw  = bus.IR_Write_o;
    v.pcw  = bus.PC_Write_o;
    v.br   = bus.Branch_o;
    v.srca = bus.ALU_Src_A_o;
    v.srcb = bus.ALU_Src_B_o;
    v.op   = bus.ALU_Op_o;
    v.m2r  = bus.Mem_to_Reg_o;
    v.rw   = bus.Reg_Write_o;
    v.to   = bus.Mem_Timeout_o;
    return v;
  endfunction

  function automatic vec_t strobeMask();
    vec_t m = '0;
    m.rd = 1'b1; m.wr = 1'b1; m.irw = 1'b1; m.pcw = 1'b1;
    m.br = 1'b1; m.m2r = 1'b1; m.rw = 1'b1;
    return m;
  endfunction

  function automatic vec_t fetchVec(input bit rdy);
    vec_t v = '0;
    v.rd = 1'b1; v.srcb = 2'b01; v.op = 3'b011;
    v.irw = rdy; v.pcw = rdy;
    return v;
  endfunction

  function automatic vec_t decodeVec();
    vec_t v = '0;
    v.st = 3'b001; v.srcb = 2'b10; v.op = 3'b011;
    return v;
  endfunction

  function automatic vec_t memVec(input bit isLoad);
    vec_t v = '0;
    v.st = 3'b011; v.iord = 1'b1; v.rd = isLoad; v.wr = !isLoad;
    return v;
  endfunction

  function automatic vec_t wbVec(input bit isLoad);
    vec_t v = '0;
    v.st = 3'b100; v.rw = 1'b1; v.m2r = isLoad;
    return v;
  endfunction

  task automatic checkOutput(input vec_t exp, input vec_t mask, input string tag);
    vec_t obs;
    obs = observe();
    total++;
    assert ((obs & mask) === (exp & mask)) else begin
      bad++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs & mask, exp & mask);
    end
  endtask

  // ALU selects are only defined in FETCH/DECODE/EXECUTE; IorD only in memory phases.
  task automatic pushVec(input vec_t v, input bit aluChk, input bit iordChk, input bit rdy,
                         input string tag);
    vec_t m = '1;
    v.to = sticky;
    if (!aluChk) begin m.srca = 1'b0; m.srcb = 2'b00; m.op = 3'b000; end
    if (!iordChk) m.iord = 1'b0;
    expQ.push_back(v);
    mskQ.push_back(m);
    rdyQ.push_back(rdy);
    tagQ.push_back(tag);
  endtask

  task automatic memPhase(input int waits, input bit isFetch, input bit isLoad, output bit done);
    int n;
    n = (waits <= T) ? waits : T + 1;
    for (int i = 0; i < n; i++) begin
      if (isFetch) pushVec(fetchVec(1'b0), 1'b1, 1'b1, 1'b0, "fetch_wait");
      else         pushVec(memVec(isLoad), 1'b0, 1'b1, 1'b0, "mem_wait");
    end
    if (waits > T) begin
      sticky = 1'b1;
      done   = 1'b0;
    end else begin
      if (isFetch) pushVec(fetchVec(1'b1), 1'b1, 1'b1, 1'b1, "fetch_ready");
      else         pushVec(memVec(isLoad), 1'b0, 1'b1, 1'b1, "mem_ready");
      done = 1'b1;
    end
  endtask

  task automatic runOne(input bit rdy, input vec_t exp, input vec_t mask, input string tag);
    bus.Mem_Ready_i = rdy;
    bus.Zero_i      = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput(exp, mask, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic runQueue(input logic [6:0] op);
    bus.OP_i = op;
    for (int i = 0; i < expQ.size(); i++) runOne(rdyQ[i], expQ[i], mskQ[i], tagQ[i]);
    expQ.delete(); mskQ.delete(); rdyQ.delete(); tagQ.delete();
  endtask

  // Builds the whole expected trace of one instruction, then replays it.
  task automatic applyStimulus(input logic [6:0] op, input int wf, input int wm);
    vec_t e;
    bit   ok, legal, toWb, toMem, isLoad;
    memPhase(wf, 1'b1, 1'b0, ok);
    if (ok) begin
      pushVec(decodeVec(), 1'b1, 1'b0, 1'b0, "decode");
      e = '0; e.st = 3'b010; e.srca = 1'b1;
      legal = 1'b1; toWb = 1'b0; toMem = 1'b0; isLoad = 1'b0;
      case (op)
        7'h33: begin e.srcb = 2'b00; e.op = 3'b000; toWb = 1'b1; end
        7'h13: begin e.srcb = 2'b10; e.op = 3'b001; toWb = 1'b1; end
        7'h37: begin e.srcb = 2'b10; e.op = 3'b010; toWb = 1'b1; end
        7'h03: begin e.srcb = 2'b10; e.op = 3'b011; toMem = 1'b1; isLoad = 1'b1; end
        7'h23: begin e.srcb = 2'b10; e.op = 3'b011; toMem = 1'b1; end
        7'h63: begin e.srcb = 2'b00; e.op = 3'b100; e.br = 1'b1; end
        default: legal = 1'b0;
      endcase
      if (legal) begin
        pushVec(e, 1'b1, 1'b0, 1'b0, "execute");
        if (toMem) begin
          memPhase(wm, 1'b0, isLoad, ok);
          if (ok && isLoad) pushVec(wbVec(1'b1), 1'b0, 1'b0, 1'b0, "writeback_load");
        end
        if (toWb) pushVec(wbVec(1'b0), 1'b0, 1'b0, 1'b0, "writeback");
      end
    end
    runQueue(op);
  endtask

  task automatic resetDut(input int cycles);
    vec_t m;
    m = strobeMask(); m.st = 3'b111; m.to = 1'b1;
    reset = 1'b1;
    bus.Mem_Ready_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput('0, m, "reset_state");
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    sticky = 1'b0;
  endtask

  logic [6:0] opTable [7] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h7F};

  initial begin
    int   wf, wm, idx;
    vec_t e;
    bus.OP_i        = 7'h00;
    bus.Zero_i      = 1'b0;
    bus.Mem_Ready_i = 1'b0;
    $display("[TB] start, MEM_TIMEOUT=%0d", T);

    resetDut(2);

    applyStimulus(7'h33, 0, 0);
    applyStimulus(7'h03, 0, 3);
    applyStimulus(7'h63, 0, 0);
    applyStimulus(7'h13, 2, 0);
    applyStimulus(7'h37, 0, 0);
    applyStimulus(7'h23, 1, 4);
    applyStimulus(7'h03, 4, 0);
    applyStimulus(7'h33, 6, 0);
    applyStimulus(7'h33, 0, 0);
    applyStimulus(7'h23, 0, 5);
    applyStimulus(7'h63, 0, 0);

    for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
      idx = $urandom_range(0, 5);
`else
      idx = $urandom_range(0, 6);
`endif
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 4);
      applyStimulus(opTable[idx], wf, wm);
    end

    // Reset in the middle of a STORE's memory access must kill the write that same cycle.
    pushVec(fetchVec(1'b1), 1'b1, 1'b1, 1'b1, "store_fetch");
    pushVec(decodeVec(), 1'b1, 1'b0, 1'b0, "store_decode");
    e = '0; e.st = 3'b010; e.srca = 1'b1; e.srcb = 2'b10; e.op = 3'b011;
    pushVec(e, 1'b1, 1'b0, 1'b0, "store_execute");
    pushVec(memVec(1'b0), 1'b0, 1'b1, 1'b0, "store_mem_wait");
    runQueue(7'h23);
    reset = 1'b1;
    bus.Mem_Ready_i = 1'b0;
    @(negedge clk);
    checkOutput('0, strobeMask(), "reset_during_store");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    sticky = 1'b0;
    applyStimulus(7'h03, 0, 2);
    applyStimulus(7'h33, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    pushVec(fetchVec(1'b1), 1'b1, 1'b1, 1'b1, "trap_fetch");
    pushVec(decodeVec(), 1'b1, 1'b0, 1'b0, "trap_decode");
    for (int i = 0; i < 20; i++) begin
      e = '0; e.st = 3'b110;
      pushVec(e, 1'b0, 1'b0, 1'($urandom_range(0, 1)), "trap_hold");
    end
    runQueue(7'h7F);
    resetDut(1);
    applyStimulus(7'h33, 0, 0);
`else
    applyStimulus(7'h7F, 0, 0);
    applyStimulus(7'h33, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
